// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared register-file constants and write-back entry type
package cpu_pkg;

  localparam int DATA_W        = 8;
  localparam int ADDR_W        = 3;
  localparam int NREGS         = 1 << ADDR_W;
  localparam int WB_FIFO_DEPTH = 4;

  // One pending register-file write
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // Write-back sources competing for the queue
  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } wb_src_t;

  // One-hot register select used by the busy scoreboard
  function automatic logic [NREGS-1:0] reg_onehot(input logic [ADDR_W-1:0] a);
    return NREGS'(1) << a;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - synchronous FIFO of write-back entries
module wb_fifo
  import cpu_pkg::*;
#(
  parameter  int DEPTH = WB_FIFO_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  wb_entry_t        push_entry,
  input  logic             pop,
  output wb_entry_t        head,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage array; contents need no reset because level gates every read
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // Pointers and occupancy; power-of-two depth lets pointers wrap naturally
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        level <= level + LVL_W'(1);
      end else if (do_pop && !do_push) begin
        level <= level - LVL_W'(1);
      end
    end
  end

endmodule

// File: rtl/reg_writeback_unit.sv
// rtl/reg_writeback_unit.sv - ALU/load write-back arbiter, queue drain and busy scoreboard
module reg_writeback_unit
  import cpu_pkg::*;
#(
  parameter  int FIFO_DEPTH = WB_FIFO_DEPTH,
  localparam int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              claim_valid,
  input  logic [ADDR_W-1:0] claim_addr,
  input  logic              wb_hold,
  output logic [NREGS-1:0]  busy,
  output logic              regwrite,
  output logic [ADDR_W-1:0] writeadd,
  output logic [DATA_W-1:0] writedata,
  output logic [LVL_W-1:0]  fifo_level,
  output logic              wb_err
);

  wb_src_t    last_grant;
  logic       grant_alu;
  logic       grant_mem;
  logic       push;
  wb_entry_t  push_entry;
  logic       pop;
  wb_entry_t  head;
  logic       full;
  logic       empty;

  logic [NREGS-1:0] claim_vec;
  logic [NREGS-1:0] clear_vec;
  logic [NREGS-1:0] busy_next;
  logic             claim_err;
  logic             write_err;

  // Round-robin grant: a tie goes to whichever source did not win last time
  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (alu_valid && mem_valid) begin
      if (last_grant == SRC_MEM) begin
        grant_alu = 1'b1;
      end else begin
        grant_mem = 1'b1;
      end
    end else begin
      grant_alu = alu_valid;
      grant_mem = mem_valid;
    end
  end

  // A full queue refuses entries even when a pop frees a slot this same cycle
  assign alu_ready  = rst & grant_alu & ~full;
  assign mem_ready  = rst & grant_mem & ~full;
  assign push       = (alu_valid & alu_ready) | (mem_valid & mem_ready);
  assign push_entry = grant_mem ? wb_entry_t'{addr: mem_addr, data: mem_data}
                                : wb_entry_t'{addr: alu_addr, data: alu_data};
  assign pop        = ~empty & ~wb_hold;

  // Remember the winner of each accepted transfer; starting at MEM makes ALU win first
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_grant <= SRC_MEM;
    end else if (alu_valid && alu_ready) begin
      last_grant <= SRC_ALU;
    end else if (mem_valid && mem_ready) begin
      last_grant <= SRC_MEM;
    end
  end

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .full       (full),
    .empty      (empty),
    .level      (fifo_level)
  );

  // Register-file write port: one pulse per popped entry, address/data hold otherwise
  always_ff @(posedge clk) begin
    if (!rst) begin
      regwrite  <= 1'b0;
      writeadd  <= '0;
      writedata <= '0;
    end else begin
      regwrite <= pop;
      if (pop) begin
        writeadd  <= head.addr;
        writedata <= head.data;
      end
    end
  end

  // Scoreboard update: the write in flight clears, a new claim sets, set wins on collision
  always_comb begin
    claim_vec = '0;
    clear_vec = '0;
    if (claim_valid) begin
      claim_vec = reg_onehot(claim_addr);
    end
    if (regwrite) begin
      clear_vec = reg_onehot(writeadd);
    end
    busy_next = (busy & ~clear_vec) | claim_vec;
    claim_err = claim_valid & busy[claim_addr] & ~clear_vec[claim_addr];
    write_err = regwrite & ~busy[writeadd];
  end

  // Busy bits and the sticky protocol-error flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy   <= '0;
      wb_err <= 1'b0;
    end else begin
      busy <= busy_next;
      if (claim_err || write_err) begin
        wb_err <= 1'b1;
      end
    end
  end

endmodule
